// File: rtl/gcd_engine.sv
`default_nettype none
// ============================================================================
//  Module   : gcd_engine
//  Brief    : Self-contained GCD unit (datapath + controller) with valid/ready
//             handshakes on both sides. MODE selects Euclid-by-subtraction (0)
//             or binary Stein (1). Counts RUN cycles per job, saturating.
//  Revision : 1.0  initial release
// ============================================================================
module gcd_engine #(
    parameter int WIDTH = 16,
    parameter int MODE  = 0,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [CNT_W-1:0] cycles,
    output logic             busy
);

    // Shift count for the common power of two pulled out by Stein's algorithm.
    localparam int K_W = $clog2(WIDTH) + 1;

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_RUN  = 2'd1;
    localparam logic [1:0] c_ST_DONE = 2'd2;

    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] c_CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [WIDTH-1:0] c_OP_ZERO  = {WIDTH{1'b0}};

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_result;
    logic [CNT_W-1:0] r_cycles;

    logic [WIDTH-1:0] w_a_step;
    logic [WIDTH-1:0] w_b_step;
    logic [WIDTH-1:0] w_gcd_final;
    logic             w_eq;
    logic             w_accept;
    logic             w_zero_op;
    logic             w_run_step;
    logic [CNT_W-1:0] w_cycles_inc;

    assign w_eq       = (r_a == r_b);
    assign w_accept   = (r_state == c_ST_IDLE) && in_valid;
    assign w_zero_op  = (a_in == c_OP_ZERO) || (b_in == c_OP_ZERO);
    // A reduction step happens on every RUN cycle that has not yet converged.
    assign w_run_step = (r_state == c_ST_RUN) && !w_eq;

    // Cycle counter increment, pinned at all-ones once it saturates.
    assign w_cycles_inc = (r_cycles == c_CNT_MAX) ? r_cycles : (r_cycles + c_CNT_ONE);

    generate
        if (MODE == 0) begin : g_subtractive
            // One subtraction per cycle: larger operand minus smaller.
            always_comb begin
                w_a_step = r_a;
                w_b_step = r_b;
                if (r_a > r_b) begin
                    w_a_step = r_a - r_b;
                end else begin
                    w_b_step = r_b - r_a;
                end
            end

            assign w_gcd_final = r_a;
        end else begin : g_binary
            logic [K_W-1:0] r_k;
            logic [K_W-1:0] w_k_step;

            localparam logic [K_W-1:0] c_K_ONE  = {{(K_W-1){1'b0}}, 1'b1};
            localparam logic [K_W-1:0] c_K_ZERO = {K_W{1'b0}};

            // Stein reduction: strip shared twos (tracked in k), strip lone
            // twos, otherwise subtract the smaller odd operand from the larger.
            always_comb begin
                w_a_step = r_a;
                w_b_step = r_b;
                w_k_step = r_k;
                if (!r_a[0] && !r_b[0]) begin
                    w_a_step = r_a >> 1;
                    w_b_step = r_b >> 1;
                    w_k_step = r_k + c_K_ONE;
                end else if (!r_a[0]) begin
                    w_a_step = r_a >> 1;
                end else if (!r_b[0]) begin
                    w_b_step = r_b >> 1;
                end else if (r_a > r_b) begin
                    w_a_step = r_a - r_b;
                end else begin
                    w_b_step = r_b - r_a;
                end
            end

            // Shared power-of-two exponent, cleared on every new job.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_k <= c_K_ZERO;
                end else if (w_accept) begin
                    r_k <= c_K_ZERO;
                end else if (w_run_step) begin
                    r_k <= w_k_step;
                end
            end

            // gcd never exceeds the smaller operand, so this shift cannot overflow.
            assign w_gcd_final = r_a << r_k;
        end
    endgenerate

    // Controller and operand/result/counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= c_ST_IDLE;
            r_a      <= c_OP_ZERO;
            r_b      <= c_OP_ZERO;
            r_result <= c_OP_ZERO;
            r_cycles <= c_CNT_ZERO;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_accept) begin
                        r_a      <= a_in;
                        r_b      <= b_in;
                        r_cycles <= c_CNT_ZERO;
                        if (w_zero_op) begin
                            // gcd(x,0) = x and gcd(0,0) = 0 in one step.
                            r_result <= a_in | b_in;
                            r_state  <= c_ST_DONE;
                        end else begin
                            r_state  <= c_ST_RUN;
                        end
                    end
                end
                c_ST_RUN: begin
                    r_cycles <= w_cycles_inc;
                    if (w_eq) begin
                        r_result <= w_gcd_final;
                        r_state  <= c_ST_DONE;
                    end else begin
                        r_a <= w_a_step;
                        r_b <= w_b_step;
                    end
                end
                c_ST_DONE: begin
                    if (out_ready) begin
                        r_result <= c_OP_ZERO;
                        r_state  <= c_ST_IDLE;
                    end
                end
                default: begin
                    r_result <= c_OP_ZERO;
                    r_state  <= c_ST_IDLE;
                end
            endcase
        end
    end

    // Outputs are decoded from state only; no path from in_valid/out_ready.
    assign in_ready  = (r_state == c_ST_IDLE) && !rst;
    assign out_valid = (r_state == c_ST_DONE);
    assign busy      = (r_state == c_ST_RUN);
    assign result    = r_result;
    assign cycles    = r_cycles;

endmodule
`default_nettype wire

// File: tb/tb_gcd_engine.sv
`default_nettype none
// ============================================================================
//  Module   : tb_gcd_engine
//  Brief    : Self-checking bench for gcd_engine, one instance per MODE,
//             checked against an arithmetic GCD model and a job queue.
//  Revision : 1.0  initial release
// ============================================================================
module tb_gcd_engine;

    localparam int WIDTH = 16;
    localparam int CNT_W = 32;
    localparam int N_RAND = 200;

    typedef struct {
        longint unsigned res;
        longint unsigned cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    logic             in_valid  [2];
    logic             in_ready  [2];
    logic             out_valid [2];
    logic             out_ready [2];
    logic             busy      [2];
    logic [WIDTH-1:0] a_in      [2];
    logic [WIDTH-1:0] b_in      [2];
    logic [WIDTH-1:0] result    [2];
    logic [CNT_W-1:0] cycles    [2];

    int n_vec = 0;
    int n_err = 0;
    int done_cnt [2];
    exp_t q0[$];
    exp_t q1[$];

    always #5 clk = ~clk;

    gcd_engine #(.WIDTH(WIDTH), .MODE(0), .CNT_W(CNT_W)) u_dut0 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .a_in(a_in[0]), .b_in(b_in[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .result(result[0]), .cycles(cycles[0]), .busy(busy[0])
    );

    gcd_engine #(.WIDTH(WIDTH), .MODE(1), .CNT_W(CNT_W)) u_dut1 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .a_in(a_in[1]), .b_in(b_in[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .result(result[1]), .cycles(cycles[1]), .busy(busy[1])
    );

    // ---------------- reference model ----------------
    function automatic longint unsigned ref_gcd(input longint unsigned a0, input longint unsigned b0);
        longint unsigned x = a0;
        longint unsigned y = b0;
        longint unsigned t;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    // Subtractive Euclid takes one cycle per unit of quotient in the modulo form.
    function automatic longint unsigned ref_cyc_sub(input longint unsigned a0, input longint unsigned b0);
        longint unsigned x = a0;
        longint unsigned y = b0;
        longint unsigned t;
        longint unsigned s = 0;
        if (a0 == 0 || b0 == 0) return 0;
        while (y != 0) begin
            s = s + x / y;
            t = x % y;
            x = y;
            y = t;
        end
        return s;
    endfunction

    function automatic longint unsigned ref_cyc_stein(input longint unsigned a0, input longint unsigned b0);
        longint unsigned a = a0;
        longint unsigned b = b0;
        longint unsigned n = 0;
        if (a0 == 0 || b0 == 0) return 0;
        while (a != b) begin
            n++;
            if ((a % 2 == 0) && (b % 2 == 0)) begin a = a / 2; b = b / 2; end
            else if (a % 2 == 0) a = a / 2;
            else if (b % 2 == 0) b = b / 2;
            else if (a > b) a = a - b;
            else b = b - a;
        end
        return n + 1;
    endfunction

    function automatic logic [WIDTH-1:0] rand_op(input int m);
        int unsigned t;
        if ($urandom_range(0, 15) == 0) t = 0;
        else if (m == 0) t = $urandom_range(1, 255);
        else t = $urandom_range(1, 65535);
        return t[WIDTH-1:0];
    endfunction

    task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    // ---------------- per-cycle compare ----------------
    task automatic cmp_cycle(input int m);
        exp_t e;
        int   qs;
        if (rst) begin
            if (m == 0) q0.delete(); else q1.delete();
            return;
        end
        qs = (m == 0) ? q0.size() : q1.size();
        if (out_valid[m]) begin
            if (qs == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL m%0d_spurious_result: got result=%0d with no job pending, required no out_valid", m, result[m]);
            end else begin
                e = (m == 0) ? q0[0] : q1[0];
                check($sformatf("m%0d_result", m), result[m], e.res);
                check($sformatf("m%0d_cycles", m), cycles[m], e.cyc);
                if (out_ready[m]) begin
                    if (m == 0) void'(q0.pop_front()); else void'(q1.pop_front());
                    done_cnt[m]++;
                end
            end
        end else begin
            check($sformatf("m%0d_result_idle_zero", m), result[m], 0);
        end
        if (in_valid[m] && in_ready[m]) begin
            e.res = ref_gcd(a_in[m], b_in[m]);
            e.cyc = (m == 0) ? ref_cyc_sub(a_in[m], b_in[m]) : ref_cyc_stein(a_in[m], b_in[m]);
            if (m == 0) q0.push_back(e); else q1.push_back(e);
        end
    endtask

    always @(negedge clk) begin
        cmp_cycle(0);
        cmp_cycle(1);
    end

    // ---------------- directed job driver ----------------
    task automatic run_job(input int m, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                           input int hold, input int budget,
                           output longint unsigned r, output longint unsigned c);
        int n;
        r = 0;
        c = 0;
        @(posedge clk);
        #1;
        in_valid[m]  = 1'b1;
        a_in[m]      = a;
        b_in[m]      = b;
        out_ready[m] = 1'b0;
        @(negedge clk);
        check($sformatf("m%0d_job_in_ready", m), in_ready[m], 1);
        @(posedge clk);
        #1;
        in_valid[m] = 1'b0;
        a_in[m]     = rand_op(1);
        b_in[m]     = rand_op(1);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid[m] && n < budget);
        if (!out_valid[m]) begin
            n_vec++;
            n_err++;
            $display("FAIL m%0d_job_timeout: got no out_valid after %0d cycles, required out_valid", m, n);
            return;
        end
        r = result[m];
        c = cycles[m];
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check($sformatf("m%0d_hold_valid", m), out_valid[m], 1);
            check($sformatf("m%0d_hold_result", m), result[m], r);
            check($sformatf("m%0d_hold_in_ready", m), in_ready[m], 0);
        end
        @(posedge clk);
        #1 out_ready[m] = 1'b1;
        @(posedge clk);
        #1 out_ready[m] = 1'b0;
        @(negedge clk);
        check($sformatf("m%0d_post_out_valid", m), out_valid[m], 0);
        check($sformatf("m%0d_post_in_ready", m), in_ready[m], 1);
        check($sformatf("m%0d_post_cycles_held", m), cycles[m], c);
    endtask

    // ---------------- randomized back-to-back phase ----------------
    task automatic random_phase(input int m);
        int base;
        bit stop;
        base = done_cnt[m];
        stop = 1'b0;
        fork
            begin
                bit aborted;
                int n;
                aborted = 1'b0;
                for (int i = 0; i < N_RAND && !aborted; i++) begin
                    int gap;
                    gap = $urandom_range(0, 3);
                    repeat (gap) begin
                        @(posedge clk);
                        #1;
                        in_valid[m] = 1'b0;
                        a_in[m]     = rand_op(1);
                        b_in[m]     = rand_op(1);
                    end
                    @(posedge clk);
                    #1;
                    in_valid[m] = 1'b1;
                    a_in[m]     = rand_op(m);
                    b_in[m]     = rand_op(m);
                    n = 0;
                    @(negedge clk);
                    while (!in_ready[m] && n < 5000) begin
                        @(negedge clk);
                        n++;
                    end
                    if (!in_ready[m]) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL m%0d_rand_accept_timeout: got in_ready=0 for %0d cycles, required 1", m, n);
                        aborted = 1'b1;
                    end
                    @(posedge clk);
                    #1;
                    in_valid[m] = 1'b0;
                    a_in[m]     = rand_op(1);
                    b_in[m]     = rand_op(1);
                end
                n = 0;
                while ((done_cnt[m] - base) < N_RAND && n < 5000) begin
                    @(negedge clk);
                    n++;
                end
                stop = 1'b1;
            end
            begin
                while (!stop) begin
                    @(posedge clk);
                    #1 out_ready[m] = ($urandom_range(0, 2) != 0);
                end
                out_ready[m] = 1'b0;
            end
        join
        check($sformatf("m%0d_rand_jobs_done", m), done_cnt[m] - base, N_RAND);
        check($sformatf("m%0d_rand_queue_empty", m), (m == 0) ? q0.size() : q1.size(), 0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        longint unsigned r;
        longint unsigned c;
        bit seen;
        logic [WIDTH-1:0] za [3];
        logic [WIDTH-1:0] zb [3];
        longint unsigned  zr [3];

        za[0] = 16'd0;  zb[0] = 16'd35; zr[0] = 35;
        za[1] = 16'd35; zb[1] = 16'd0;  zr[1] = 35;
        za[2] = 16'd0;  zb[2] = 16'd0;  zr[2] = 0;

        rst = 1'b1;
        for (int m = 0; m < 2; m++) begin
            in_valid[m]  = 1'b0;
            out_ready[m] = 1'b0;
            a_in[m]      = '0;
            b_in[m]      = '0;
            done_cnt[m]  = 0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int m = 0; m < 2; m++) begin
            check($sformatf("m%0d_rst_in_ready", m), in_ready[m], 0);
            check($sformatf("m%0d_rst_out_valid", m), out_valid[m], 0);
            check($sformatf("m%0d_rst_result", m), result[m], 0);
            check($sformatf("m%0d_rst_cycles", m), cycles[m], 0);
            check($sformatf("m%0d_rst_busy", m), busy[m], 0);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("m0_release_in_ready", in_ready[0], 1);
        check("m1_release_in_ready", in_ready[1], 1);

        // Hand-computed pins of the model and DUT.
        run_job(0, 16'd48, 16'd18, 3, 200, r, c);
        check("m0_48_18_result", r, 6);
        check("m0_48_18_cycles", c, 5);
        run_job(1, 16'd48, 16'd18, 0, 200, r, c);
        check("m1_48_18_result", r, 6);
        check("m1_48_18_cycles", c, 7);
        run_job(1, 16'd17, 16'd17, 1, 200, r, c);
        check("m1_17_17_result", r, 17);
        check("m1_17_17_cycles", c, 1);

        for (int m = 0; m < 2; m++) begin
            for (int i = 0; i < 3; i++) begin
                run_job(m, za[i], zb[i], 1, 50, r, c);
                check($sformatf("m%0d_zero%0d_result", m, i), r, zr[i]);
                check($sformatf("m%0d_zero%0d_cycles", m, i), c, 0);
            end
        end

        run_job(0, 16'd65535, 16'd1, 0, 70000, r, c);
        check("m0_65535_1_result", r, 1);
        check("m0_65535_1_cycles", c, 65535);
        run_job(1, 16'd65535, 16'd1, 0, 200, r, c);
        check("m1_65535_1_result", r, 1);
        check("m1_65535_1_cycles_le32", (c <= 32) ? 1 : 0, 1);

        // Reset abandons a job in flight.
        @(posedge clk);
        #1;
        in_valid[0] = 1'b1;
        a_in[0]     = 16'd1000;
        b_in[0]     = 16'd3;
        @(posedge clk);
        #1 in_valid[0] = 1'b0;
        repeat (20) @(posedge clk);
        @(negedge clk);
        check("m0_midrun_busy", busy[0], 1);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("m0_after_rst_in_ready", in_ready[0], 1);
        check("m0_after_rst_busy", busy[0], 0);
        check("m0_after_rst_cycles", cycles[0], 0);
        seen = 1'b0;
        repeat (400) begin
            @(negedge clk);
            if (out_valid[0]) seen = 1'b1;
        end
        check("m0_after_rst_no_result", seen, 0);
        run_job(0, 16'd12, 16'd8, 0, 200, r, c);
        check("m0_12_8_result", r, 4);

        random_phase(0);
        random_phase(1);

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
